lab_sprite_fetch: RTL and testbench

Pixel-pipeline stage directly upstream of the 12-bit sprite ROM: for each VGA pixel it decides whether the pixel falls inside a scaled sprite window, generates the ROM read address, absorbs the ROM's one-cycle synchronous read latency, and emits a colour-keyed RGB444 pixel plus hit flag to the screen mixer. Sprite position and horizontal mirroring are latched once per frame so the sprite never tears mid-frame.

---
 rtl/lab_sprite_fetch.sv | 121 ++++++++++++
 tb/tb_lab_sprite_fetch.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/lab_sprite_fetch.sv
// Sprite fetch stage: window test, ROM addressing, colour keying.
// Two-stage pipeline matched to a one-cycle synchronous sprite ROM.
`timescale 1ns/1ps
module lab_sprite_fetch #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 8,
  parameter int SPR_W = 20,
  parameter int SPR_H = 11,
  parameter int SCALE_LOG2 = 1,
  parameter logic [DATA_WIDTH-1:0] KEY_COLOR = 12'h0F0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pixel_tick,
  input  logic [9:0]            pixel_x,
  input  logic [9:0]            pixel_y,
  input  logic                  video_on,
  input  logic                  frame_start,
  input  logic [9:0]            pos_x,
  input  logic [9:0]            pos_y,
  input  logic                  flip_h,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] sprite_rgb,
  output logic                  sprite_hit,
  output logic                  out_valid
);

  localparam int WIN_W = SPR_W << SCALE_LOG2;
  localparam int WIN_H = SPR_H << SCALE_LOG2;

  logic [9:0]            px_q, px_d;
  logic [9:0]            py_q, py_d;
  logic                  fl_q, fl_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic                  v1_q, v1_d;
  logic                  w1_q, w1_d;
  logic                  v2_q, v2_d;
  logic                  w2_q, w2_d;
  logic                  out_valid_q, out_valid_d;
  logic                  sprite_hit_q, sprite_hit_d;
  logic [DATA_WIDTH-1:0] sprite_rgb_q, sprite_rgb_d;

  logic [10:0]           dx, dy;
  logic [10:0]           col, row;
  logic                  in_win;
  logic [ADDR_WIDTH-1:0] addr;

  // Window test and ROM address for the current pixel (frame-latched pos).
  always_comb begin
    dx = {1'b0, pixel_x} - {1'b0, px_q};
    dy = {1'b0, pixel_y} - {1'b0, py_q};
    in_win = (pixel_x >= px_q) && (pixel_y >= py_q) &&
             (dx < 11'(WIN_W)) && (dy < 11'(WIN_H));
    col = dx >> SCALE_LOG2;
    row = dy >> SCALE_LOG2;
    if (fl_q) begin
      col = 11'(SPR_W - 1) - col;
    end
    addr = ADDR_WIDTH'(row * 11'(SPR_W) + col);
  end

  // Next-state for frame latch, both pipeline stages and the outputs.
  always_comb begin
    px_d = px_q;
    py_d = py_q;
    fl_d = fl_q;
    if (frame_start) begin
      px_d = pos_x;
      py_d = pos_y;
      fl_d = flip_h;
    end
    rom_addr_d = rom_addr_q;
    w1_d = w1_q;
    if (pixel_tick) begin
      rom_addr_d = in_win ? addr : '0;
      w1_d = in_win && video_on;
    end
    v1_d = pixel_tick;
    v2_d = v1_q;
    w2_d = w1_q;
    out_valid_d = v2_q;
    sprite_hit_d = v2_q && w2_q && (rom_data != KEY_COLOR);
    sprite_rgb_d = sprite_hit_d ? rom_data : '0;
  end

  // State registers, cleared asynchronously so no stale pixel escapes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      px_q <= '0;
      py_q <= '0;
      fl_q <= 1'b0;
      rom_addr_q <= '0;
      v1_q <= 1'b0;
      w1_q <= 1'b0;
      v2_q <= 1'b0;
      w2_q <= 1'b0;
      out_valid_q <= 1'b0;
      sprite_hit_q <= 1'b0;
      sprite_rgb_q <= '0;
    end else begin
      px_q <= px_d;
      py_q <= py_d;
      fl_q <= fl_d;
      rom_addr_q <= rom_addr_d;
      v1_q <= v1_d;
      w1_q <= w1_d;
      v2_q <= v2_d;
      w2_q <= w2_d;
      out_valid_q <= out_valid_d;
      sprite_hit_q <= sprite_hit_d;
      sprite_rgb_q <= sprite_rgb_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign out_valid = out_valid_q;
  assign sprite_hit = sprite_hit_q;
  assign sprite_rgb = sprite_rgb_q;

endmodule

// File: tb/tb_lab_sprite_fetch.sv
// Scoreboard bench for lab_sprite_fetch with a behavioural sprite model.
// Stimulus pushes expectations; monitors pop on rom_addr / out_valid.
`timescale 1ns/1ps
module tb_lab_sprite_fetch;

  localparam int SW = 20;
  localparam int SH = 11;
  localparam int SL = 1;
  localparam logic [11:0] KEY = 12'h0F0;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pixel_tick;
  logic [9:0]  pixel_x, pixel_y;
  logic        video_on;
  logic        frame_start;
  logic [9:0]  pos_x, pos_y;
  logic        flip_h;
  logic [7:0]  rom_addr;
  logic [11:0] rom_data;
  logic [11:0] sprite_rgb;
  logic        sprite_hit;
  logic        out_valid;

  lab_sprite_fetch dut (
    .clk(clk), .reset_n(reset_n),
    .pixel_tick(pixel_tick),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on),
    .frame_start(frame_start),
    .pos_x(pos_x), .pos_y(pos_y),
    .flip_h(flip_h),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .sprite_rgb(sprite_rgb),
    .sprite_hit(sprite_hit),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  logic [11:0] rom [256];
  always @(posedge clk) rom_data <= rom[rom_addr];

  typedef struct {
    logic        hit;
    logic [11:0] rgb;
    int          cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] addr_q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int m_px = 0, m_py = 0;
  bit m_fl = 0;
  logic tick_seen;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge reset_n)
    if (!reset_n) tick_seen <= 1'b0;
    else tick_seen <= pixel_tick;

  function automatic void chk(input string n, input int a, input int e);
    tests++;
    if (a != e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", n, a, e, $time);
    end
  endfunction

  // Monitor: address one clk after a tick, pixel whenever out_valid.
  always @(negedge clk) begin
    if (tick_seen) begin
      if (addr_q.size() == 0) chk("addr_unexpected", 1, 0);
      else chk("rom_addr", int'(rom_addr), int'(addr_q.pop_front()));
    end
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("out_spurious", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_latency", cyc, e.cyc);
        chk("sprite_hit", int'(sprite_hit), int'(e.hit));
        chk("sprite_rgb", int'(sprite_rgb), int'(e.rgb));
      end
    end else begin
      chk("idle_out", int'({sprite_hit, sprite_rgb}), 0);
    end
  end

  // One clock of stimulus; expectation comes from the sprite rules.
  task automatic drive(input bit tick, input int x, input int y,
                       input bit von, input bit fs,
                       input int nx, input int ny, input bit nf);
    int dx, dy, col, row, a;
    bit inw;
    exp_t e;
    @(posedge clk);
    #2;
    pixel_tick = tick;
    pixel_x = x[9:0];
    pixel_y = y[9:0];
    video_on = von;
    frame_start = fs;
    pos_x = nx[9:0];
    pos_y = ny[9:0];
    flip_h = nf;
    if (tick) begin
      dx = x - m_px;
      dy = y - m_py;
      inw = dx >= 0 && dy >= 0 &&
            dx < SW * (1 << SL) && dy < SH * (1 << SL);
      col = dx / (1 << SL);
      row = dy / (1 << SL);
      if (m_fl) col = SW - 1 - col;
      a = inw ? row * SW + col : 0;
      addr_q.push_back(a[7:0]);
      e.hit = inw && von && (rom[a] != KEY);
      e.rgb = e.hit ? rom[a] : 12'h000;
      e.cyc = cyc + 3;
      exp_q.push_back(e);
    end
    if (fs) begin
      m_px = nx;
      m_py = ny;
      m_fl = nf;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 1, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    pixel_tick = 0; pixel_x = 0; pixel_y = 0;
    video_on = 0; frame_start = 0;
    pos_x = 0; pos_y = 0; flip_h = 0;
    for (int i = 0; i < 256; i++)
      rom[i] = ($urandom_range(0, 7) == 0) ? KEY
               : 12'($urandom_range(0, 4095));
    rom[0] = 12'hF00;
    rom[5] = KEY;
    rom[219] = 12'h00F;
    #3;
    chk("reset_addr", int'(rom_addr), 0);
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_hit", int'(sprite_hit), 0);
    chk("reset_rgb", int'(sprite_rgb), 0);
    @(posedge clk);
    #2 reset_n = 1'b1;

    drive(0, 0, 0, 1, 1, 100, 50, 0);
    drive(1, 100, 50, 1, 0, 0, 0, 0);
    drive(1, 139, 71, 1, 0, 0, 0, 0);
    drive(1, 140, 50, 1, 0, 0, 0, 0);
    drive(1, 99, 50, 1, 0, 0, 0, 0);
    drive(1, 100, 72, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 100, 50, 1);
    drive(1, 100, 50, 1, 0, 0, 0, 0);
    drive(1, 139, 50, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 100, 50, 0);
    drive(1, 110, 50, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 1, 0, 0, 0);
    drive(1, 1, 0, 1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    idle(4);

    drive(0, 0, 0, 1, 1, 30, 5, 0);
    for (int i = 0; i < 4; i++) drive(1, 26 + i, 5, 1, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    pixel_tick = 0;
    frame_start = 0;
    #1;
    chk("midreset_addr", int'(rom_addr), 0);
    chk("midreset_valid", int'(out_valid), 0);
    chk("midreset_hit", int'(sprite_hit), 0);
    chk("midreset_rgb", int'(sprite_rgb), 0);
    exp_q.delete();
    addr_q.delete();
    m_px = 0; m_py = 0; m_fl = 0;
    @(posedge clk);
    #2 reset_n = 1'b1;
    for (int i = 4; i < 10; i++) drive(1, 26 + i, 5, 1, 0, 0, 0, 0);
    idle(4);

    for (int n = 0; n < 400; n++) begin
      int x, y, nx, ny;
      bit fs, tk, von, nf;
      fs = ($urandom_range(0, 15) == 0);
      nx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(990, 1023))
                                       : int'($urandom_range(0, 300));
      ny = int'($urandom_range(0, 300));
      nf = 1'($urandom_range(0, 1));
      tk = ($urandom_range(0, 3) != 0);
      von = ($urandom_range(0, 7) != 0);
      x = m_px + int'($urandom_range(0, 50)) - 5;
      y = m_py + int'($urandom_range(0, 28)) - 3;
      if (x < 0) x = 0;
      if (x > 1023) x = 1023;
      if (y < 0) y = 0;
      if (y > 1023) y = 1023;
      drive(tk, x, y, von, fs, nx, ny, nf);
    end
    idle(5);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("addr_q_drained", addr_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
